// File: rtl/neopixel_pkg.sv
// Shared timing defaults and FSM state encoding for the NeoPixel strand controller.
package neopixel_pkg;

    localparam int DEF_NUM_PIXELS = 8;
    localparam int DEF_T0H        = 18;
    localparam int DEF_T0L        = 40;
    localparam int DEF_T1H        = 35;
    localparam int DEF_T1L        = 30;
    localparam int DEF_TRESET     = 2500;

    typedef enum logic [1:0] {
        IDLE,
        BIT_HIGH,
        BIT_LOW,
        LATCH
    } state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/neopixel_strand_controller_if.sv
// Host-side port bundle: pixel buffer writes, frame requests and the ready status.
interface neopixel_strand_controller_if #(
    parameter int AW = 3
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          go;
    logic          continuous;
    logic          ready;

    modport master (
        output wr_en, wr_addr, wr_data, go, continuous,
        input  ready
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, go, continuous,
        output ready
    );
endinterface

// File: rtl/neopixel_bit_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module neopixel_bit_timer #(
    parameter int WIDTH = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);
endmodule

// File: rtl/neopixel_strand_controller.sv
// WS2812-style strand driver: pixel buffer plus a bit-serial FSM that emits one
// frame (pixel 0 first, MSB first) followed by a low latch interval.
module neopixel_strand_controller
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int T0H        = DEF_T0H,
    parameter int T0L        = DEF_T0L,
    parameter int T1H        = DEF_T1H,
    parameter int T1L        = DEF_T1L,
    parameter int TRESET     = DEF_TRESET
) (
    input  logic                          clock,
    input  logic                          reset,
    neopixel_strand_controller_if.slave   host,
    output logic                          neopixel_data
);
    localparam int AW    = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int T_MAX = max_of(TRESET, max_of(max_of(T0H, T0L), max_of(T1H, T1L)));
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [AW:0]   NP        = (AW+1)'(NUM_PIXELS);
    localparam logic [AW-1:0] LAST_PIX  = AW'(NUM_PIXELS - 1);
    // Timer is loaded with duration-1 so each state lasts exactly the duration.
    localparam logic [TW-1:0] LD_T0H    = TW'(T0H - 1);
    localparam logic [TW-1:0] LD_T0L    = TW'(T0L - 1);
    localparam logic [TW-1:0] LD_T1H    = TW'(T1H - 1);
    localparam logic [TW-1:0] LD_T1L    = TW'(T1L - 1);
    localparam logic [TW-1:0] LD_TRESET = TW'(TRESET - 1);

    state_t        state_q, state_d;
    logic          ready_q, ready_d;
    logic          init_q, init_d;
    logic          data_q, data_d;
    logic [23:0]   shift_q, shift_d;
    logic [4:0]    bit_idx_q, bit_idx_d;
    logic [AW-1:0] pix_idx_q, pix_idx_d;

    logic [23:0]   pix_buf [NUM_PIXELS];
    logic          write_ok, start, last_bit, timer_load, timer_done;
    logic [TW-1:0] timer_value;
    logic [AW-1:0] next_pix;
    logic [23:0]   word0, next_word;

    assign write_ok  = host.wr_en && ready_q && ({1'b0, host.wr_addr} < NP);
    // A write landing on the start edge must already drive the first bit.
    assign word0     = (write_ok && (host.wr_addr == '0)) ? host.wr_data : pix_buf[0];
    assign next_pix  = pix_idx_q + 1'b1;
    assign next_word = ({1'b0, next_pix} < NP) ? pix_buf[next_pix] : '0;
    assign start     = (state_q == IDLE) &&
                       (init_q || (ready_q && (host.go || host.continuous)));
    assign last_bit  = (bit_idx_q == 5'd23) && (pix_idx_q == LAST_PIX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                pix_buf[i] <= '0;
            end
        end else if (write_ok) begin
            pix_buf[host.wr_addr] <= host.wr_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        init_d      = init_q;
        data_d      = data_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        pix_idx_d   = pix_idx_q;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = BIT_HIGH;
                    ready_d     = 1'b0;
                    init_d      = 1'b0;
                    data_d      = 1'b1;
                    shift_d     = word0;
                    bit_idx_d   = '0;
                    pix_idx_d   = '0;
                    timer_load  = 1'b1;
                    timer_value = word0[23] ? LD_T1H : LD_T0H;
                end
            end
            BIT_HIGH: begin
                if (timer_done) begin
                    state_d     = BIT_LOW;
                    data_d      = 1'b0;
                    timer_load  = 1'b1;
                    timer_value = shift_q[23] ? LD_T1L : LD_T0L;
                end
            end
            BIT_LOW: begin
                if (timer_done) begin
                    if (last_bit) begin
                        state_d     = LATCH;
                        bit_idx_d   = '0;
                        pix_idx_d   = '0;
                        timer_load  = 1'b1;
                        timer_value = LD_TRESET;
                    end else begin
                        if (bit_idx_q == 5'd23) begin
                            shift_d   = next_word;
                            bit_idx_d = '0;
                            pix_idx_d = next_pix;
                        end else begin
                            shift_d   = {shift_q[22:0], 1'b0};
                            bit_idx_d = bit_idx_q + 5'd1;
                        end
                        state_d     = BIT_HIGH;
                        data_d      = 1'b1;
                        timer_load  = 1'b1;
                        timer_value = shift_d[23] ? LD_T1H : LD_T0H;
                    end
                end
            end
            LATCH: begin
                if (timer_done) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // init_q forces the all-zero frame that follows every reset release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            init_q    <= 1'b1;
            data_q    <= 1'b0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            pix_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            init_q    <= init_d;
            data_q    <= data_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            pix_idx_q <= pix_idx_d;
        end
    end

    neopixel_bit_timer #(
        .WIDTH(TW)
    ) u_bit_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    assign neopixel_data = data_q;
    assign host.ready    = ready_q;
endmodule
